// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer sizing for the synchronous FIFO.
package sync_fifo_pkg;
   localparam int DEFAULT_DATA_WIDTH = 8;
   localparam int DEFAULT_DEPTH      = 8;

   // One address bit per entry index plus a wrap bit separating full from empty.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   typedef logic [ptr_w(DEFAULT_DEPTH)-1:0] ptr_t;
endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DATA_WIDTH simple dual-port array: synchronous write, registered read.
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  re_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Storage is deliberately left unreset; only the read register clears.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)     rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers. Define SYNC_FIFO_COUNT_EN to add
// the occupancy output `count`.
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    write_en,
   input  logic                    read_en,
   input  logic [DATA_WIDTH-1:0]   data_in,
   output logic                    full,
   output logic                    empty,
`ifdef SYNC_FIFO_COUNT_EN
   output logic [$clog2(DEPTH):0]  count,
`endif
   output logic [DATA_WIDTH-1:0]   data_out
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = ptr_w(DEPTH);
   typedef logic [PW-1:0] fifo_ptr_t;
   localparam fifo_ptr_t PTR_ONE = fifo_ptr_t'(1);

   fifo_ptr_t wr_ptr_q, wr_ptr_d;
   fifo_ptr_t rd_ptr_q, rd_ptr_d;
   logic      wr_acc, rd_acc;

   assign empty  = (wr_ptr_q == rd_ptr_q);
   assign full   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign wr_acc = write_en && !full;
   assign rd_acc = read_en && !empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

`ifdef SYNC_FIFO_COUNT_EN
   logic [AW:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;
`endif

   sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_mem (
      .clk_i   (clk),
      .rst_i   (rst),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (data_in),
      .re_i    (rd_acc),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (data_out)
   );
endmodule

// File: tb/tb_sync_fifo.sv
// Directed and seeded-random checks for sync_fifo (DATA_WIDTH=8, DEPTH=8).
module tb_sync_fifo;
   localparam int DEPTH = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       write_en = 1'b0;
   logic       read_en = 1'b0;
   logic [7:0] data_in = '0;
   logic       full, empty;
   logic [7:0] data_out;
`ifdef SYNC_FIFO_COUNT_EN
   logic [3:0] count;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0] q [$];
   logic [7:0] exp_dout = '0;

   always #5 clk = ~clk;

   sync_fifo #(.DATA_WIDTH(8), .DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .write_en (write_en),
      .read_en  (read_en),
      .data_in  (data_in),
      .full     (full),
      .empty    (empty),
`ifdef SYNC_FIFO_COUNT_EN
      .count    (count),
`endif
      .data_out (data_out)
   );

   // Drive one cycle and advance the reference queue; no comparisons here.
   task automatic step(input logic we, input logic re, input logic [7:0] din);
      logic wacc, racc;
      write_en = we;
      read_en  = re;
      data_in  = din;
      wacc = we && (q.size() < DEPTH);
      racc = re && (q.size() > 0);
      if (racc) exp_dout = q.pop_front();
      if (wacc) q.push_back(din);
      @(posedge clk);
      #1;
      write_en = 1'b0;
      read_en  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #15;
      rst = 1'b0;
      #2;
      checks++;
      if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
      checks++;
      if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
      checks++;
      if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", data_out); end
`ifdef SYNC_FIFO_COUNT_EN
      checks++;
      if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
`endif
   endtask

   task automatic test_fill_drain();
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 1'b0, 8'(i));
         if (i == 7) begin
            checks++;
            if (full !== 1'b0) begin errors++; $display("FAIL fill_full7 got %b want 0", full); end
         end
      end
      checks++;
      if (full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL fill_full8 got full=%b empty=%b want 1 0", full, empty); end
      for (int i = 1; i <= 8; i++) begin
         step(1'b0, 1'b1, 8'h00);
         checks++;
         if (data_out !== 8'(i)) begin errors++; $display("FAIL drain_dout%0d got %h want %h", i, data_out, 8'(i)); end
      end
      checks++;
      if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL drain_empty got empty=%b full=%b want 1 0", empty, full); end
   endtask

   task automatic test_overflow_underflow();
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h10 + 8'(i));
      step(1'b1, 1'b0, 8'hAA);
      checks++;
      if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", full); end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 8'h00);
         checks++;
         if (data_out !== 8'h10 + 8'(i)) begin errors++; $display("FAIL ovf_dout%0d got %h want %h", i, data_out, 8'h10 + 8'(i)); end
      end
      checks++;
      if (empty !== 1'b1) begin errors++; $display("FAIL ovf_aa_dropped got empty=%b want 1", empty); end
      step(1'b0, 1'b1, 8'h00);
      step(1'b0, 1'b1, 8'h00);
      checks++;
      if (data_out !== 8'h17) begin errors++; $display("FAIL udf_hold got %h want 17", data_out); end
      checks++;
      if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL udf_flags got empty=%b full=%b want 1 0", empty, full); end
   endtask

   task automatic test_simultaneous();
      logic [7:0] want;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h21 + 8'(i));
      for (int k = 0; k < 10; k++) begin
         step(1'b1, 1'b1, 8'h30 + 8'(k));
         want = (k < 3) ? 8'h21 + 8'(k) : 8'h30 + 8'(k - 3);
         checks++;
         if (data_out !== want) begin errors++; $display("FAIL simul_dout%0d got %h want %h", k, data_out, want); end
         checks++;
         if (empty !== 1'b0 || full !== 1'b0) begin errors++; $display("FAIL simul_flags%0d got empty=%b full=%b want 0 0", k, empty, full); end
`ifdef SYNC_FIFO_COUNT_EN
         checks++;
         if (count !== 4'd3) begin errors++; $display("FAIL simul_count%0d got %0d want 3", k, count); end
`endif
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b1, 8'h00);
         checks++;
         if (data_out !== 8'h37 + 8'(i)) begin errors++; $display("FAIL simul_tail%0d got %h want %h", i, data_out, 8'h37 + 8'(i)); end
      end
      // Full case: only the read may be accepted; 8'hEE is lost.
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h40 + 8'(i));
      step(1'b1, 1'b1, 8'hEE);
      checks++;
      if (data_out !== 8'h40 || full !== 1'b0) begin errors++; $display("FAIL simul_full got dout=%h full=%b want 40 0", data_out, full); end
`ifdef SYNC_FIFO_COUNT_EN
      checks++;
      if (count !== 4'd7) begin errors++; $display("FAIL simul_full_count got %0d want 7", count); end
`endif
      for (int i = 1; i < 8; i++) begin
         step(1'b0, 1'b1, 8'h00);
         checks++;
         if (data_out !== 8'h40 + 8'(i)) begin errors++; $display("FAIL simul_full_drain%0d got %h want %h", i, data_out, 8'h40 + 8'(i)); end
      end
      checks++;
      if (empty !== 1'b1) begin errors++; $display("FAIL simul_full_empty got %b want 1", empty); end
      // Empty case: write accepted, no bypass to data_out.
      step(1'b1, 1'b1, 8'h5C);
      checks++;
      if (data_out !== 8'h47 || empty !== 1'b0) begin errors++; $display("FAIL simul_empty got dout=%h empty=%b want 47 0", data_out, empty); end
      step(1'b0, 1'b1, 8'h00);
      checks++;
      if (data_out !== 8'h5C || empty !== 1'b1) begin errors++; $display("FAIL simul_empty_read got dout=%h empty=%b want 5c 1", data_out, empty); end
   endtask

   task automatic test_wrap();
      int len, mode;
      logic we, re;
      void'($urandom(32'h5EED));
      for (int b = 0; b < 20; b++) begin
         len  = $urandom_range(1, 8);
         mode = $urandom_range(0, 2);
         for (int c = 0; c < len; c++) begin
            we = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            re = (mode == 1) ? 1'b1 : (mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            step(we, re, 8'($urandom_range(0, 255)));
            checks++;
            if (data_out !== exp_dout) begin errors++; $display("FAIL wrap_dout b%0d c%0d got %h want %h", b, c, data_out, exp_dout); end
            checks++;
            if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin
               errors++; $display("FAIL wrap_flags b%0d c%0d got empty=%b full=%b occ=%0d", b, c, empty, full, q.size());
            end
`ifdef SYNC_FIFO_COUNT_EN
            checks++;
            if (count !== 4'(q.size())) begin errors++; $display("FAIL wrap_count b%0d c%0d got %0d want %0d", b, c, count, q.size()); end
`endif
         end
      end
      while (q.size() > 0) begin
         step(1'b0, 1'b1, 8'h00);
         checks++;
         if (data_out !== exp_dout) begin errors++; $display("FAIL wrap_drain got %h want %h", data_out, exp_dout); end
      end
   endtask

   task automatic test_mid_reset();
      step(1'b1, 1'b0, 8'h51);
      step(1'b1, 1'b0, 8'h52);
      step(1'b1, 1'b1, 8'h53);
      #3;
      rst = 1'b1;
      #1;
      q.delete();
      exp_dout = 8'h00;
      checks++;
      if (empty !== 1'b1 || full !== 1'b0 || data_out !== 8'h00) begin
         errors++; $display("FAIL midrst_async got empty=%b full=%b dout=%h want 1 0 00", empty, full, data_out);
      end
`ifdef SYNC_FIFO_COUNT_EN
      checks++;
      if (count !== 4'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", count); end
`endif
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;
      step(1'b1, 1'b0, 8'h61);
      step(1'b0, 1'b1, 8'h00);
      checks++;
      if (data_out !== 8'h61 || empty !== 1'b1) begin errors++; $display("FAIL midrst_stale got dout=%h empty=%b want 61 1", data_out, empty); end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_overflow_underflow();
      test_simultaneous();
      test_wrap();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
